// File: rtl/ula_seq_if.sv
// Operand/result bundle between a requester and the sequential ALU.
// The master drives the request fields; the slave (the ALU) drives status and results.
interface ula_seq_if;
  logic        start;
  logic [31:0] inA;
  logic [31:0] inB;
  logic [3:0]  func;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        zero;

  modport master (
    output start, inA, inB, func,
    input  busy, done, result, overflow, zero
  );

  modport slave (
    input  start, inA, inB, func,
    output busy, done, result, overflow, zero
  );
endinterface

// File: rtl/ula_seq.sv
// Sequential 32-bit ALU: one-cycle add/sub/and/or, 32-iteration shift-add multiply
// and restoring divide on operand magnitudes, three-state IDLE/CALC/DONE control.
module ula_seq (
  input  logic      clk,
  input  logic      rst_n,
  ula_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [3:0] F_ADD = 4'b0000;
  localparam logic [3:0] F_SUB = 4'b0001;
  localparam logic [3:0] F_MUL = 4'b0010;
  localparam logic [3:0] F_DIV = 4'b0011;
  localparam logic [3:0] F_AND = 4'b0100;
  localparam logic [3:0] F_OR  = 4'b0101;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        is_mul_q, is_mul_d;
  logic        neg_q, neg_d;
  logic [31:0] opnd_q, opnd_d;
  logic [63:0] work_q, work_d;
  logic [31:0] result_q, result_d;
  logic        ovf_q, ovf_d;
  logic        zero_q, zero_d;

  logic [31:0] a_mag, b_mag, sum_ab, diff_ab;
  logic        add_ovf, sub_ovf, div_by_zero, div_min_neg1;
  logic [32:0] mul_sum, div_shift, div_trial;
  logic [63:0] mul_next, div_next, iter_next, mul_signed;
  logic [31:0] quo_signed;
  logic        mul_ovf;

  assign a_mag   = bus.inA[31] ? -bus.inA : bus.inA;
  assign b_mag   = bus.inB[31] ? -bus.inB : bus.inB;
  assign sum_ab  = bus.inA + bus.inB;
  assign diff_ab = bus.inA - bus.inB;
  assign add_ovf = (bus.inA[31] == bus.inB[31]) && (sum_ab[31] != bus.inA[31]);
  assign sub_ovf = (bus.inA[31] != bus.inB[31]) && (diff_ab[31] != bus.inA[31]);
  assign div_by_zero  = (bus.inB == 32'd0);
  assign div_min_neg1 = (bus.inA == 32'h8000_0000) && (bus.inB == 32'hFFFF_FFFF);

  // Multiply: work = {partial_hi, multiplier}; add multiplicand when the LSB is set, then shift right.
  assign mul_sum  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_next = {mul_sum, work_q[31:1]};

  // Divide: work = {remainder, dividend/quotient}; quotient bits shift in from the right.
  assign div_shift = {work_q[63:32], work_q[31]};
  assign div_trial = div_shift - {1'b0, opnd_q};
  assign div_next  = div_trial[32] ? {div_shift[31:0], work_q[30:0], 1'b0}
                                   : {div_trial[31:0], work_q[30:0], 1'b1};

  assign iter_next  = is_mul_q ? mul_next : div_next;
  assign mul_signed = neg_q ? -iter_next : iter_next;
  assign quo_signed = neg_q ? -iter_next[31:0] : iter_next[31:0];
  assign mul_ovf    = !((&mul_signed[63:31]) || !(|mul_signed[63:31]));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_mul_d = is_mul_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    work_d   = work_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = DONE;
          case (bus.func)
            F_ADD: begin result_d = sum_ab;  ovf_d = add_ovf; end
            F_SUB: begin result_d = diff_ab; ovf_d = sub_ovf; end
            F_AND: begin result_d = bus.inA & bus.inB; ovf_d = 1'b0; end
            F_OR:  begin result_d = bus.inA | bus.inB; ovf_d = 1'b0; end
            F_MUL: begin
              state_d  = CALC;
              cnt_d    = 6'd0;
              is_mul_d = 1'b1;
              neg_d    = bus.inA[31] ^ bus.inB[31];
              opnd_d   = a_mag;
              work_d   = {32'd0, b_mag};
            end
            F_DIV: begin
              if (div_by_zero) begin
                result_d = 32'd0;
                ovf_d    = 1'b1;
              end else if (div_min_neg1) begin
                result_d = 32'h8000_0000;
                ovf_d    = 1'b1;
              end else begin
                state_d  = CALC;
                cnt_d    = 6'd0;
                is_mul_d = 1'b0;
                neg_d    = bus.inA[31] ^ bus.inB[31];
                opnd_d   = b_mag;
                work_d   = {32'd0, a_mag};
              end
            end
            default: begin result_d = 32'd0; ovf_d = 1'b0; end
          endcase
          if (state_d == DONE) zero_d = (result_d == 32'd0);
        end
      end
      CALC: begin
        work_d = iter_next;
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d  = DONE;
          result_d = is_mul_q ? mul_signed[31:0] : quo_signed;
          ovf_d    = is_mul_q ? mul_ovf : 1'b0;
          zero_d   = (result_d == 32'd0);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      is_mul_q <= 1'b0;
      neg_q    <= 1'b0;
      opnd_q   <= 32'd0;
      work_q   <= 64'd0;
      result_q <= 32'd0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_mul_q <= is_mul_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      work_q   <= work_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.result   = result_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq: a vector table of single operations plus
// hand-written sequences for ignored start, back-to-back issue and mid-operation reset.
module tb_ula_seq;

  typedef struct {
    string       name;
    logic [3:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    int          lat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t vecs[18];

  ula_seq_if bus ();

  ula_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op at the next negedge, scramble inputs after accept, then measure latency.
  task automatic do_op(input vec_t v);
    int   lat;
    logic got;
    logic busy_ok;
    logic [31:0] res_seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.func  = v.func;
    bus.inA   = v.a;
    bus.inB   = v.b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.func  = 4'b0000;
    bus.inA   = ~v.a;
    bus.inB   = v.b + 32'd17;
    lat = 0;
    got = 1'b0;
    busy_ok = 1'b1;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (bus.done) got = 1'b1;
      else if (!bus.busy) busy_ok = 1'b0;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done within 60 cycles", v.name);
    end else begin
      res_seen = bus.result;
      chk({v.name, " latency"},  32'(lat),          32'(v.lat));
      chk({v.name, " result"},   bus.result,        v.res);
      chk({v.name, " overflow"}, {31'd0, bus.overflow}, {31'd0, v.ovf});
      chk({v.name, " zero"},     {31'd0, bus.zero}, {31'd0, (v.res == 32'd0)});
      chk({v.name, " busy"},     {31'd0, busy_ok && bus.busy}, 32'd1);
      @(negedge clk);
      chk({v.name, " done pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
      chk({v.name, " hold"},       bus.result, v.res);
      $display("op %-10s a=%h b=%h -> result=%h ovf=%0d zero=%0d lat=%0d",
               v.name, v.a, v.b, res_seen, bus.overflow, bus.zero, lat);
    end
  endtask

  initial begin
    int ndone;
    logic [31:0] res_at_done;
    vec_t v;

    checks = 0;
    errors = 0;
    vecs[0]  = '{"add_ovf",  4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1};
    vecs[1]  = '{"sub_zero", 4'b0001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1};
    vecs[2]  = '{"mul_neg",  4'b0010, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 1'b0, 33};
    vecs[3]  = '{"mul_ovf",  4'b0010, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 33};
    vecs[4]  = '{"div_neg",  4'b0011, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33};
    vecs[5]  = '{"div_by0",  4'b0011, 32'h0000_0009, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};
    vecs[6]  = '{"div_min",  4'b0011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1};
    vecs[7]  = '{"and",      4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1};
    vecs[8]  = '{"or",       4'b0101, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1};
    vecs[9]  = '{"unsup7",   4'b0111, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b0, 1};
    vecs[10] = '{"sub_ovf",  4'b0001, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1};
    vecs[11] = '{"add_m1p1", 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1};
    vecs[12] = '{"div_n100", 4'b0011, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFF2, 1'b0, 33};
    vecs[13] = '{"mul_min1", 4'b0010, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, 33};
    vecs[14] = '{"mul_nn",   4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33};
    vecs[15] = '{"div_min1", 4'b0011, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, 33};
    vecs[16] = '{"mul_p2_31",4'b0010, 32'h4000_0000, 32'h0000_0002, 32'h8000_0000, 1'b1, 33};
    vecs[17] = '{"unsupF",   4'b1111, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b0, 1};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.func  = 4'd0;
    bus.inA   = 32'd0;
    bus.inB   = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset outputs", {27'd0, bus.busy, bus.done, bus.overflow, bus.zero, 1'b0}, 32'd0);
    chk("reset result", bus.result, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 18; i++) do_op(vecs[i]);

    // A start pulsed during a multiply is dropped; exactly one done carries 6*7.
    @(negedge clk);
    bus.start = 1'b1; bus.func = 4'b0010; bus.inA = 32'd6; bus.inB = 32'd7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.func = 4'b0000; bus.inA = 32'd1; bus.inB = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    res_at_done = 32'hDEAD_BEEF;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        res_at_done = bus.result;
      end
    end
    chk("ignored start done count", 32'(ndone), 32'd1);
    chk("ignored start result", res_at_done, 32'h0000_002A);
    $display("op ignore    mul 6*7 with add pulsed in CALC -> dones=%0d result=%h", ndone, res_at_done);

    // Start held high: accepted again in the IDLE cycle after DONE.
    @(negedge clk);
    bus.start = 1'b1; bus.func = 4'b0000; bus.inA = 32'd10; bus.inB = 32'd20;
    @(negedge clk);
    chk("b2b first done", {31'd0, bus.done}, 32'd1);
    chk("b2b first result", bus.result, 32'd30);
    bus.inA = 32'd1; bus.inB = 32'd1;
    @(negedge clk);
    chk("b2b gap", {30'd0, bus.done, bus.busy}, 32'd0);
    @(negedge clk);
    chk("b2b second done", {31'd0, bus.done}, 32'd1);
    chk("b2b second result", bus.result, 32'd2);
    bus.start = 1'b0;
    $display("op b2b       add 10+20 then 1+1 with start held -> result=%h", bus.result);
    repeat (2) @(negedge clk);

    // Reset during a divide aborts it at once and clears every output.
    @(negedge clk);
    bus.start = 1'b1; bus.func = 4'b0011; bus.inA = 32'd1000; bus.inB = 32'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset flags", {28'd0, bus.busy, bus.done, bus.overflow, bus.zero}, 32'd0);
    chk("midreset result", bus.result, 32'd0);
    @(negedge clk);
    chk("midreset hold", {28'd0, bus.busy, bus.done, bus.overflow, bus.zero}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    $display("op midreset  div 1000/3 aborted at iteration 10");
    v = '{"add_post", 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 1};
    do_op(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_seq.md
ULA_SEQ -- requirements
Module: ula_seq

Interface
REQ-001 The module SHALL have one clock; reset is asynchronous and active-low.
REQ-002 The module SHALL have no parameters; all widths are fixed.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  operation request; sampled on clk rising edge.
REQ-006 inA  input  32  signed operand A; captured on accept.
REQ-007 inB  input  32  signed operand B; captured on accept.
REQ-008 func  input  4  operation code, captured on accept. Codes: 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 and, 0101 or.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 done  output  1  one-cycle pulse; result, overflow and zero are valid while it is high.
REQ-011 result  output  32  signed registered result.
REQ-012 overflow  output  1  registered overflow / error flag.
REQ-013 zero  output  1  registered flag, high when result equals 0.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-015 Accept SHALL occur on a rising edge with start=1 and state=IDLE; at accept inA, inB and func are latched internally.
REQ-016 start SHALL be ignored in CALC and DONE; such a request is lost, not queued.
REQ-017 For add, sub, and, or, unsupported codes and divide special cases, accept SHALL go IDLE->DONE with outputs registered on the same edge, so done is high in the cycle after accept (latency 1).
REQ-018 For mul and for div with non-special operands, accept SHALL go IDLE->CALC and clear a 6-bit iteration counter.
REQ-019 CALC SHALL run exactly 32 iterations, one per edge; on the 32nd edge it registers the outputs and goes to DONE, so done is high 33 cycles after accept.
REQ-020 DONE SHALL always go to IDLE on the next edge; done=1 only in DONE.
REQ-021 Add and sub SHALL be two's-complement wrap-around; overflow=1 when operand signs make a same-sign add, or an opposite-sign subtract, flip the sign of the result.
REQ-022 And and or SHALL be bitwise with overflow=0.
REQ-023 Mul SHALL use an iterative shift-add on operand magnitudes, with the sign applied at the end.
REQ-024 Mul result SHALL be bits [31:0] of the 64-bit signed product; overflow=1 when bits [63:31] are not all equal.
REQ-025 Div SHALL use iterative restoring division on magnitudes; the quotient truncates toward zero and takes the sign of the XOR of the operand signs.
REQ-026 Div overflow SHALL be 0 for non-special operands; the remainder is discarded.
REQ-027 Div with inB=0 SHALL give result=0 and overflow=1 with latency 1.
REQ-028 Div of 32'h80000000 by 32'hFFFFFFFF SHALL give result=32'h80000000 and overflow=1 with latency 1.
REQ-029 Unsupported func codes (0110-1111) SHALL give result=0, overflow=0 and zero=1 with latency 1.
REQ-030 zero SHALL be registered together with result and equal (result==0) for every completed operation.
REQ-031 result, overflow and zero SHALL hold their values from done until the next operation completes; they do not change during CALC.
REQ-032 Changes on inA, inB or func after accept SHALL have no effect on the operation in progress.
REQ-033 Back-to-back operation: start held high continuously SHALL be accepted again in the cycle after DONE (IDLE), giving a minimum issue interval of 2 cycles.

Reset
REQ-034 While rst_n=0, state SHALL be IDLE and busy=0, done=0, result=0, overflow=0, zero=0, with the counter and internal registers cleared.
REQ-035 Reset asserted mid-operation (in CALC or DONE) SHALL abort the operation immediately; no done pulse is produced for it.
REQ-036 The first rising edge after rst_n deasserts SHALL be able to accept start.

Verification
REQ-037 Add overflow: add, inA=32'h7FFFFFFF, inB=1 -> done 1 cycle after accept, result=32'h80000000, overflow=1, zero=0.
REQ-038 Sub to zero: sub, inA=5, inB=5 -> result=0, zero=1, overflow=0, latency 1.
REQ-039 Mul timing and sign:
- mul -3*7 -> busy for 33 cycles, done on cycle 33, result=32'hFFFFFFEB, overflow=0.
- mul 32'h00010000*32'h00010000 -> result=0, overflow=1, zero=1.
REQ-040 Div cases:
- div 7/-2 -> result=32'hFFFFFFFD, latency 33.
- div 9/0 -> result=0, overflow=1, latency 1.
- div 32'h80000000/-1 -> result=32'h80000000, overflow=1.
REQ-041 Ignored start: a second start with func=add pulsed during CALC of a mul -> exactly one done, carrying the mul result; the add is lost.
REQ-042 Reset mid-operation: rst_n=0 at iteration 10 of a div -> busy=0 and all outputs 0 at once; a new add after release completes with latency 1.
